commit_store_buffer: RTL and testbench

- Sits in the LSU, directly downstream of the commit stage.
- Holds issued-but-uncommitted stores in a speculative queue.
- On the commit stage's store commit strobe, moves the oldest speculative store into a commit queue.
- Drains the commit queue to the data cache through a req/gnt/ack handshake.
- Produces the commit-ready and no-store-pending signals the commit stage consumes.

---
 rtl/commit_store_buffer.sv | 245 ++++++++++++++++++++++++
 tb/tb_commit_store_buffer.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/commit_store_buffer.sv
// Store buffer between commit and the data cache: a speculative queue of issued stores feeds a
// commit queue that drains over req/gnt/ack. Optional load page-offset hazard check: STBUF_PAGE_OFFSET_CHECK_EN.
module commit_store_buffer #(
    parameter int unsigned SPEC_DEPTH   = 4,
    parameter int unsigned COMMIT_DEPTH = 8,
    parameter int unsigned PLEN         = 56,
    parameter int unsigned XLEN         = 64
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                flush_i,
    input  logic                valid_i,
    output logic                ready_o,
    input  logic [PLEN-1:0]     paddr_i,
    input  logic [XLEN-1:0]     data_i,
    input  logic [XLEN/8-1:0]   be_i,
    input  logic [1:0]          data_size_i,
    input  logic                commit_i,
    output logic                commit_ready_o,
    output logic                no_st_pending_o,
    output logic                req_o,
    input  logic                gnt_i,
    input  logic                ack_i,
    output logic [PLEN-1:0]     addr_o,
    output logic [XLEN-1:0]     wdata_o,
    output logic [XLEN/8-1:0]   be_o,
    output logic [1:0]          size_o,
    input  logic [11:0]         page_offset_i,
    output logic                page_offset_matches_o
);

    localparam int unsigned SPW = $clog2(SPEC_DEPTH);
    localparam int unsigned CMW = $clog2(COMMIT_DEPTH);
    localparam int unsigned BEW = XLEN / 8;
    localparam logic [SPW:0] SPEC_FULL = (SPW+1)'(SPEC_DEPTH);
    localparam logic [CMW:0] CM_FULL   = (CMW+1)'(COMMIT_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } state_t;

    // ---------------- speculative queue ----------------
    logic [PLEN-1:0] spec_addr_mem [SPEC_DEPTH];
    logic [XLEN-1:0] spec_data_mem [SPEC_DEPTH];
    logic [BEW-1:0]  spec_be_mem   [SPEC_DEPTH];
    logic [1:0]      spec_size_mem [SPEC_DEPTH];

    logic [SPW-1:0]  spec_head_reg, spec_head_next;
    logic [SPW-1:0]  spec_tail_reg, spec_tail_next;
    logic [SPW:0]    spec_cnt_reg,  spec_cnt_next;

    // ---------------- commit queue ----------------
    logic [PLEN-1:0] cm_addr_mem [COMMIT_DEPTH];
    logic [XLEN-1:0] cm_data_mem [COMMIT_DEPTH];
    logic [BEW-1:0]  cm_be_mem   [COMMIT_DEPTH];
    logic [1:0]      cm_size_mem [COMMIT_DEPTH];

    logic [CMW-1:0]  cm_head_reg, cm_head_next;
    logic [CMW-1:0]  cm_tail_reg, cm_tail_next;
    logic [CMW:0]    cm_cnt_reg,  cm_cnt_next;

    state_t          state_reg, state_next;

    logic            spec_push;
    logic            spec_pop;
    logic            drain_pop;

    assign ready_o        = (spec_cnt_reg != SPEC_FULL);
    assign commit_ready_o = (cm_cnt_reg != CM_FULL);
    assign no_st_pending_o = (spec_cnt_reg == '0) && (cm_cnt_reg == '0) && (state_reg == IDLE);

    // A push in a flush cycle is dropped; an illegal commit is ignored rather than corrupting state.
    assign spec_push = valid_i && ready_o && !flush_i;
    assign spec_pop  = commit_i && (spec_cnt_reg != '0) && commit_ready_o;

    always_comb begin
        spec_head_next = spec_head_reg;
        spec_tail_next = spec_tail_reg;
        spec_cnt_next  = spec_cnt_reg;
        if (flush_i) begin
            spec_head_next = '0;
            spec_tail_next = '0;
            spec_cnt_next  = '0;
        end else begin
            if (spec_push) begin
                spec_tail_next = spec_tail_reg + SPW'(1);
            end
            if (spec_pop) begin
                spec_head_next = spec_head_reg + SPW'(1);
            end
            spec_cnt_next = spec_cnt_reg + (SPW+1)'(spec_push) - (SPW+1)'(spec_pop);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            spec_head_reg <= '0;
            spec_tail_reg <= '0;
            spec_cnt_reg  <= '0;
        end else begin
            spec_head_reg <= spec_head_next;
            spec_tail_reg <= spec_tail_next;
            spec_cnt_reg  <= spec_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (spec_push) begin
            spec_addr_mem[spec_tail_reg] <= paddr_i;
            spec_data_mem[spec_tail_reg] <= data_i;
            spec_be_mem[spec_tail_reg]   <= be_i;
            spec_size_mem[spec_tail_reg] <= data_size_i;
        end
    end

    always_comb begin
        cm_head_next = cm_head_reg;
        cm_tail_next = cm_tail_reg;
        if (spec_pop) begin
            cm_tail_next = cm_tail_reg + CMW'(1);
        end
        if (drain_pop) begin
            cm_head_next = cm_head_reg + CMW'(1);
        end
        cm_cnt_next = cm_cnt_reg + (CMW+1)'(spec_pop) - (CMW+1)'(drain_pop);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cm_head_reg <= '0;
            cm_tail_reg <= '0;
            cm_cnt_reg  <= '0;
        end else begin
            cm_head_reg <= cm_head_next;
            cm_tail_reg <= cm_tail_next;
            cm_cnt_reg  <= cm_cnt_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (spec_pop) begin
            cm_addr_mem[cm_tail_reg] <= spec_addr_mem[spec_head_reg];
            cm_data_mem[cm_tail_reg] <= spec_data_mem[spec_head_reg];
            cm_be_mem[cm_tail_reg]   <= spec_be_mem[spec_head_reg];
            cm_size_mem[cm_tail_reg] <= spec_size_mem[spec_head_reg];
        end
    end

    // ---------------- drain FSM ----------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Payload comes straight from the commit queue head, which cannot move until gnt_i.
    always_comb begin
        state_next = state_reg;
        req_o      = 1'b0;
        drain_pop  = 1'b0;
        addr_o     = '0;
        wdata_o    = '0;
        be_o       = '0;
        size_o     = '0;
        unique case (state_reg)
            IDLE: begin
                if (cm_cnt_reg != '0) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                req_o   = 1'b1;
                addr_o  = cm_addr_mem[cm_head_reg];
                wdata_o = cm_data_mem[cm_head_reg];
                be_o    = cm_be_mem[cm_head_reg];
                size_o  = cm_size_mem[cm_head_reg];
                if (gnt_i) begin
                    drain_pop  = 1'b1;
                    state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_i) begin
                    state_next = (cm_cnt_reg != '0) ? REQ : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    genvar gi;

`ifdef STBUF_PAGE_OFFSET_CHECK_EN
    // Only the doubleword index of the in-flight store matters for the load hazard compare.
    logic [8:0]              inflight_ofs_reg;
    logic [SPEC_DEPTH-1:0]   spec_hit;
    logic [COMMIT_DEPTH-1:0] cm_hit;
    logic                    inflight_hit;
    logic                    unused_offset_lsbs;

    assign unused_offset_lsbs = ^page_offset_i[2:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            inflight_ofs_reg <= '0;
        end else if (drain_pop) begin
            inflight_ofs_reg <= cm_addr_mem[cm_head_reg][11:3];
        end
    end

    generate
        for (gi = 0; gi < SPEC_DEPTH; gi++) begin : g_spec_hit
            logic [SPW-1:0] spec_age;
            assign spec_age     = SPW'(gi) - spec_head_reg;
            assign spec_hit[gi] = ({1'b0, spec_age} < spec_cnt_reg) &&
                                  (spec_addr_mem[gi][11:3] == page_offset_i[11:3]);
        end
        for (gi = 0; gi < COMMIT_DEPTH; gi++) begin : g_cm_hit
            logic [CMW-1:0] cm_age;
            assign cm_age     = CMW'(gi) - cm_head_reg;
            assign cm_hit[gi] = ({1'b0, cm_age} < cm_cnt_reg) &&
                                (cm_addr_mem[gi][11:3] == page_offset_i[11:3]);
        end
    endgenerate

    // During REQ the in-flight entry is still the commit queue head, so it is already covered.
    assign inflight_hit = (state_reg == WAIT_ACK) && (inflight_ofs_reg == page_offset_i[11:3]);
    assign page_offset_matches_o = (|spec_hit) || (|cm_hit) || inflight_hit;
`else
    logic unused_page_offset;
    assign unused_page_offset    = ^page_offset_i;
    assign page_offset_matches_o = 1'b0;
`endif

    // The commit stage must never commit from an empty speculative queue or into a full commit queue.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
        commit_i |-> ((spec_cnt_reg != '0) && commit_ready_o));

endmodule

// File: tb/tb_commit_store_buffer.sv
// Directed bench for commit_store_buffer; expected values are hand-computed per vector.
// Define STBUF_PAGE_OFFSET_CHECK_EN to match an RTL build with the page-offset check enabled.
module tb_commit_store_buffer;

    localparam int PLEN = 56;
    localparam int XLEN = 64;

`ifdef STBUF_PAGE_OFFSET_CHECK_EN
    localparam logic EXP_MATCH = 1'b1;
`else
    localparam logic EXP_MATCH = 1'b0;
`endif

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              flush_i;
    logic              valid_i;
    logic              ready_o;
    logic [PLEN-1:0]   paddr_i;
    logic [XLEN-1:0]   data_i;
    logic [XLEN/8-1:0] be_i;
    logic [1:0]        data_size_i;
    logic              commit_i;
    logic              commit_ready_o;
    logic              no_st_pending_o;
    logic              req_o;
    logic              gnt_i;
    logic              ack_i;
    logic [PLEN-1:0]   addr_o;
    logic [XLEN-1:0]   wdata_o;
    logic [XLEN/8-1:0] be_o;
    logic [1:0]        size_o;
    logic [11:0]       page_offset_i;
    logic              page_offset_matches_o;

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk_i = ~clk_i;

    commit_store_buffer dut (
        .clk_i                 (clk_i),
        .rst_ni                (rst_ni),
        .flush_i               (flush_i),
        .valid_i               (valid_i),
        .ready_o               (ready_o),
        .paddr_i               (paddr_i),
        .data_i                (data_i),
        .be_i                  (be_i),
        .data_size_i           (data_size_i),
        .commit_i              (commit_i),
        .commit_ready_o        (commit_ready_o),
        .no_st_pending_o       (no_st_pending_o),
        .req_o                 (req_o),
        .gnt_i                 (gnt_i),
        .ack_i                 (ack_i),
        .addr_o                (addr_o),
        .wdata_o               (wdata_o),
        .be_o                  (be_o),
        .size_o                (size_o),
        .page_offset_i         (page_offset_i),
        .page_offset_matches_o (page_offset_matches_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_store(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d);
        valid_i     = 1'b1;
        paddr_i     = a;
        data_i      = d;
        be_i        = 8'hFF;
        data_size_i = 2'd3;
    endtask

    task automatic wait_req(input int max_cycles, input string tag);
        int n = 0;
        while (!req_o && n < max_cycles) begin
            step();
            n++;
        end
        check({tag, "_req"}, 64'(req_o), 64'd1);
    endtask

    task automatic drain_one(input logic [PLEN-1:0] a, input logic [XLEN-1:0] d, input string tag);
        wait_req(8, tag);
        check({tag, "_addr"}, 64'(addr_o), 64'(a));
        check({tag, "_wdata"}, wdata_o, d);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check({tag, "_req_low_wait_ack"}, 64'(req_o), 64'd0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw_req;
        rst_ni        = 1'b0;
        flush_i       = 1'b0;
        valid_i       = 1'b0;
        paddr_i       = '0;
        data_i        = '0;
        be_i          = '0;
        data_size_i   = '0;
        commit_i      = 1'b0;
        gnt_i         = 1'b0;
        ack_i         = 1'b0;
        page_offset_i = '0;

        // Reset state
        #12;
        check("rst_ready", 64'(ready_o), 64'd1);
        check("rst_commit_ready", 64'(commit_ready_o), 64'd1);
        check("rst_no_st_pending", 64'(no_st_pending_o), 64'd1);
        check("rst_req", 64'(req_o), 64'd0);
        check("rst_addr", 64'(addr_o), 64'd0);
        check("rst_matches", 64'(page_offset_matches_o), 64'd0);
        step();
        rst_ni = 1'b1;
        step();

        // Single store: commit in cycle N, req_o in N+2, ack 3 cycles after gnt
        drive_store(56'h1000, 64'hAA);
        step();
        valid_i = 1'b0;
        check("t1_pending_after_push", 64'(no_st_pending_o), 64'd0);
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        check("t1_req_n1", 64'(req_o), 64'd0);
        step();
        check("t1_req_n2", 64'(req_o), 64'd1);
        check("t1_addr", 64'(addr_o), 64'h1000);
        check("t1_wdata", wdata_o, 64'hAA);
        check("t1_be", 64'(be_o), 64'hFF);
        check("t1_size", 64'(size_o), 64'd3);
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("t1_req_after_gnt", 64'(req_o), 64'd0);
        step();
        step();
        check("t1_pending_before_ack", 64'(no_st_pending_o), 64'd0);
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("t1_no_pending_after_ack", 64'(no_st_pending_o), 64'd1);

        // Fill speculative queue, drop 5th, flush (push in flush cycle also dropped)
        for (int i = 0; i < 4; i++) begin
            drive_store(56'h2000 + 56'(i * 8), 64'hB0 + 64'(i));
            step();
        end
        check("t2_ready_full", 64'(ready_o), 64'd0);
        drive_store(56'h2100, 64'hBF);
        step();
        check("t2_ready_still_full", 64'(ready_o), 64'd0);
        check("t2_pending", 64'(no_st_pending_o), 64'd0);
        drive_store(56'h2200, 64'hBE);
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        valid_i = 1'b0;
        check("t2_ready_after_flush", 64'(ready_o), 64'd1);
        check("t2_no_pending_after_flush", 64'(no_st_pending_o), 64'd1);
        check("t2_req_after_flush", 64'(req_o), 64'd0);

        // Commit 8 stores with gnt held low, then drain in FIFO order
        for (int k = 0; k <= 8; k++) begin
            if (k < 8) drive_store(56'h3000 + 56'(k * 8), 64'hD000 + 64'(k));
            else valid_i = 1'b0;
            commit_i = (k > 0);
            if (k == 8) check("t3_commit_ready_before_8th", 64'(commit_ready_o), 64'd1);
            step();
        end
        valid_i  = 1'b0;
        commit_i = 1'b0;
        check("t3_commit_ready_full", 64'(commit_ready_o), 64'd0);
        check("t3_req_held", 64'(req_o), 64'd1);
        check("t3_addr_held", 64'(addr_o), 64'h3000);
        step();
        step();
        check("t3_req_stable", 64'(req_o), 64'd1);
        check("t3_addr_stable", 64'(addr_o), 64'h3000);
        check("t3_wdata_stable", wdata_o, 64'hD000);
        for (int k = 0; k < 8; k++) begin
            drain_one(56'h3000 + 56'(k * 8), 64'hD000 + 64'(k), $sformatf("t3_drain%0d", k));
        end
        check("t3_no_pending_end", 64'(no_st_pending_o), 64'd1);

        // Commit + flush in the same cycle with 3 speculative entries
        for (int i = 0; i < 3; i++) begin
            drive_store(56'h4000 + 56'(i * 8), 64'hE0 + 64'(i));
            step();
        end
        valid_i  = 1'b0;
        commit_i = 1'b1;
        flush_i  = 1'b1;
        step();
        commit_i = 1'b0;
        flush_i  = 1'b0;
        drain_one(56'h4000, 64'hE0, "t4_oldest");
        saw_req = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_o) saw_req = 1;
            step();
        end
        check("t4_no_extra_req", 64'(saw_req), 64'd0);
        check("t4_no_pending", 64'(no_st_pending_o), 64'd1);

        // Asynchronous reset while a write is outstanding
        drive_store(56'h5000, 64'hF0);
        step();
        drive_store(56'h5008, 64'hF1);
        commit_i = 1'b1;
        step();
        valid_i = 1'b0;
        step();
        commit_i = 1'b0;
        wait_req(8, "t5");
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("t5_pending_before_rst", 64'(no_st_pending_o), 64'd0);
        rst_ni = 1'b0;
        #2;
        check("t5_async_no_pending", 64'(no_st_pending_o), 64'd1);
        check("t5_async_ready", 64'(ready_o), 64'd1);
        check("t5_async_commit_ready", 64'(commit_ready_o), 64'd1);
        check("t5_async_req", 64'(req_o), 64'd0);
        check("t5_async_addr", 64'(addr_o), 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        saw_req = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (req_o) saw_req = 1;
        end
        check("t5_no_req_after_rst", 64'(saw_req), 64'd0);

        // Page-offset match against a pending store at 0x2A48
        drive_store(56'h2A48, 64'h55);
        step();
        valid_i = 1'b0;
        page_offset_i = 12'hA48;
        #1;
        check("t6_spec_match", 64'(page_offset_matches_o), 64'(EXP_MATCH));
        page_offset_i = 12'hA50;
        #1;
        check("t6_spec_nomatch", 64'(page_offset_matches_o), 64'd0);
        page_offset_i = 12'hA48;
        commit_i = 1'b1;
        step();
        commit_i = 1'b0;
        check("t6_commitq_match", 64'(page_offset_matches_o), 64'(EXP_MATCH));
        wait_req(8, "t6");
        gnt_i = 1'b1;
        step();
        gnt_i = 1'b0;
        check("t6_inflight_match", 64'(page_offset_matches_o), 64'(EXP_MATCH));
        ack_i = 1'b1;
        step();
        ack_i = 1'b0;
        check("t6_idle_nomatch", 64'(page_offset_matches_o), 64'd0);
        check("t6_no_pending", 64'(no_st_pending_o), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
